// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage ARM core: forward-select
// encodings, the PC register index and the hazard-unit shadow records.
package arm_pipe_pkg;

  // Register address width the shadow records are laid out for.
  localparam int PKG_REG_AW = 4;

  // EX operand source selects.
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_RESULTW = 2'b01;
  localparam logic [1:0] FWD_ALURESM = 2'b10;

  // R15 reads the PC, so it is never a forwarding target.
  localparam logic [PKG_REG_AW-1:0] REG_PC = 4'd15;

  // Per-instruction hazard info carried through E.
  typedef struct packed {
    logic [PKG_REG_AW-1:0] wa;
    logic                  regwrite;
    logic                  memtoreg;
    logic                  mul;
    logic [PKG_REG_AW-1:0] ra1;
    logic [PKG_REG_AW-1:0] ra2;
  } stage_shadow_t;

  // M and W only need to know which register they will write.
  typedef struct packed {
    logic [PKG_REG_AW-1:0] wa;
    logic                  regwrite;
  } wb_shadow_t;

  localparam stage_shadow_t SHADOW_BUBBLE = '0;
  localparam wb_shadow_t    WB_BUBBLE     = '0;

  // Width of the multiply busy counter; must be able to hold MUL_LAT-1.
  function automatic int mul_cnt_w(input int lat);
    return (lat < 2) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Operand forward select for one EX source register. M is newer than W
// and wins; R15 always comes from the register-file path.
module hazard_fwd_sel
  import arm_pipe_pkg::*;
#(
  parameter int REG_AW = PKG_REG_AW
) (
  input  logic [REG_AW-1:0] i_ra,
  input  logic [REG_AW-1:0] i_wa_m,
  input  logic              i_regwrite_m,
  input  logic [REG_AW-1:0] i_wa_w,
  input  logic              i_regwrite_w,
  output logic [1:0]        o_fwd
);

  localparam logic [REG_AW-1:0] PC_ADDR = REG_AW'(REG_PC);

  logic w_hit_m;
  logic w_hit_w;

  assign w_hit_m = i_regwrite_m && (i_wa_m == i_ra);
  assign w_hit_w = i_regwrite_w && (i_wa_w == i_ra);

  // Priority compare: M result, then W result, else register file.
  always_comb begin
    o_fwd = FWD_REGFILE;
    if (i_ra != PC_ADDR) begin
      if (w_hit_m)      o_fwd = FWD_ALURESM;
      else if (w_hit_w) o_fwd = FWD_RESULTW;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: keeps a shadow of the E/M/W hazard fields,
// drives the EX forwarding muxes, load-use stalls, branch flushes and the
// multi-cycle multiply hold of EX.
module hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int REG_AW  = PKG_REG_AW,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ValidD,
  input  logic [REG_AW-1:0] RA1D,
  input  logic [REG_AW-1:0] RA2D,
  input  logic [REG_AW-1:0] WA3D,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MulD,
  input  logic              BranchTakenE,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM
);

  localparam int               CNT_W    = mul_cnt_w(MUL_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             MUL_HOLD = (MUL_LAT > 1);

  // Shadow pipeline and multiply counter.
  stage_shadow_t    r_e;
  wb_shadow_t       r_m;
  wb_shadow_t       r_w;
  logic [CNT_W-1:0] r_cnt;

  stage_shadow_t    w_d;
  stage_shadow_t    w_e_nxt;
  wb_shadow_t       w_m_nxt;
  wb_shadow_t       w_w_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_busy;
  logic w_ld_raw;
  logic w_ld;
  logic w_br;
  logic w_flush_e;
  logic w_stall_fd;
  logic w_d_enter;

  logic [1:0][PKG_REG_AW-1:0] w_ra_e;
  logic [1:0][1:0]            w_fwd;

  // Pack the Decode-stage fields into a shadow record.
  always_comb begin
    w_d          = SHADOW_BUBBLE;
    w_d.wa       = PKG_REG_AW'(WA3D);
    w_d.regwrite = RegWriteD;
    w_d.memtoreg = MemtoRegD;
    w_d.mul      = MulD;
    w_d.ra1      = PKG_REG_AW'(RA1D);
    w_d.ra2      = PKG_REG_AW'(RA2D);
  end

  // Hazard detection. A multiply holding EX masks everything else, since
  // nothing in D may move and the instruction in E is not a load/branch.
  always_comb begin
    w_busy     = r_e.mul && (r_cnt != '0);
    w_ld_raw   = ValidD && r_e.regwrite && r_e.memtoreg &&
                 ((r_e.wa == w_d.ra1) || (r_e.wa == w_d.ra2));
    w_ld       = w_ld_raw && !w_busy;
    w_br       = BranchTakenE && !w_busy;
    w_flush_e  = w_br || w_ld;
    // A taken branch squashes the consumer, so the load-use hold is moot.
    w_stall_fd = w_busy || (w_ld && !w_br);
    w_d_enter  = ValidD && !w_flush_e;
  end

  // Forward compare for SrcA (index 0) and SrcB (index 1).
  assign w_ra_e = {r_e.ra2, r_e.ra1};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    hazard_fwd_sel #(
      .REG_AW (PKG_REG_AW)
    ) u_sel (
      .i_ra         (w_ra_e[g]),
      .i_wa_m       (r_m.wa),
      .i_regwrite_m (r_m.regwrite),
      .i_wa_w       (r_w.wa),
      .i_regwrite_w (r_w.regwrite),
      .o_fwd        (w_fwd[g])
    );
  end

  // Next shadow state: hold E and bubble M while the multiply is busy,
  // otherwise shift D->E->M->W with E bubbled on a flush or empty slot.
  always_comb begin
    w_e_nxt   = r_e;
    w_m_nxt   = r_m;
    w_w_nxt   = r_m;
    w_cnt_nxt = r_cnt;
    if (w_busy) begin
      w_m_nxt   = WB_BUBBLE;
      w_cnt_nxt = r_cnt - CNT_ONE;
    end else begin
      w_m_nxt.wa       = r_e.wa;
      w_m_nxt.regwrite = r_e.regwrite;
      w_e_nxt          = w_d_enter ? w_d : SHADOW_BUBBLE;
      w_cnt_nxt        = (w_d_enter && MulD && MUL_HOLD) ? CNT_LOAD : '0;
    end
  end

  // Shadow and counter registers; reset abandons any multiply in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_e   <= SHADOW_BUBBLE;
      r_m   <= WB_BUBBLE;
      r_w   <= WB_BUBBLE;
      r_cnt <= '0;
    end else begin
      r_e   <= w_e_nxt;
      r_m   <= w_m_nxt;
      r_w   <= w_w_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Control outputs, forced quiet while reset is held.
  always_comb begin
    ForwardA = FWD_REGFILE;
    ForwardB = FWD_REGFILE;
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    FlushM   = 1'b0;
    if (reset_n) begin
      ForwardA = w_fwd[0];
      ForwardB = w_fwd[1];
      StallF   = w_stall_fd;
      StallD   = w_stall_fd;
      StallE   = w_busy;
      FlushD   = w_br;
      FlushE   = w_flush_e;
      FlushM   = w_busy;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MUL_LAT = 3). Inputs change 1ns after
// the rising edge; outputs are checked before the next rising edge.
// ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM}, fwd = {FwdA, FwdB}.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset_n;
  logic       ValidD;
  logic [3:0] RA1D, RA2D, WA3D;
  logic       RegWriteD, MemtoRegD, MulD, BranchTakenE;
  logic [1:0] ForwardA, ForwardB;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;

  int checks   = 0;
  int failures = 0;

  logic [5:0] ctl;
  logic [3:0] fwd;
  assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};
  assign fwd = {ForwardA, ForwardB};

  localparam logic [5:0] C_NONE   = 6'b000000;
  localparam logic [5:0] C_LDUSE  = 6'b110010;
  localparam logic [5:0] C_MULBSY = 6'b111001;
  localparam logic [5:0] C_BRANCH = 6'b000110;

  hazard_ctrl #(
    .REG_AW  (4),
    .MUL_LAT (3)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ValidD       (ValidD),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3D         (WA3D),
    .RegWriteD    (RegWriteD),
    .MemtoRegD    (MemtoRegD),
    .MulD         (MulD),
    .BranchTakenE (BranchTakenE),
    .ForwardA     (ForwardA),
    .ForwardB     (ForwardB),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushM       (FlushM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic v, input logic [3:0] a1, input logic [3:0] a2,
                         input logic [3:0] wa, input logic rw, input logic mtr,
                         input logic ml);
    ValidD    = v;
    RA1D      = a1;
    RA2D      = a2;
    WA3D      = wa;
    RegWriteD = rw;
    MemtoRegD = mtr;
    MulD      = ml;
  endtask

  task automatic drive_nop();
    drive_d(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    drive_nop();
    BranchTakenE = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_d(1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b1);
    BranchTakenE = 1'b1;
    #3;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_NONE); end
    checks++;
    if (fwd !== 4'b0000) begin failures++; $display("FAIL reset_fwd got=%b exp=%b", fwd, 4'b0000); end
    BranchTakenE = 1'b0;
    drive_nop();
    #10 reset_n = 1'b1;
    tick();
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, C_NONE); end
  endtask

  task automatic test_back_to_back();
    // ADD R1 ; ADD R2,R1,R3 -> consumer sees R1 in M
    drain();
    drive_d(1'b1, 4'd9, 4'd10, 4'd1, 1'b1, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (fwd !== 4'b1000) begin failures++; $display("FAIL fwd_dist1 got=%b exp=%b", fwd, 4'b1000); end
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL fwd_dist1_ctl got=%b exp=%b", ctl, C_NONE); end
    // one independent instruction between -> R1 in W
    drain();
    drive_d(1'b1, 4'd9, 4'd10, 4'd1, 1'b1, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd12, 4'd13, 4'd11, 1'b1, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (fwd !== 4'b0100) begin failures++; $display("FAIL fwd_dist2 got=%b exp=%b", fwd, 4'b0100); end
    // two between -> R1 retired, register file
    drain();
    drive_d(1'b1, 4'd9, 4'd10, 4'd1, 1'b1, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd12, 4'd13, 4'd11, 1'b1, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd12, 4'd13, 4'd14, 1'b1, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd1, 4'd3, 4'd2, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (fwd !== 4'b0000) begin failures++; $display("FAIL fwd_dist3 got=%b exp=%b", fwd, 4'b0000); end
    // SrcB dependency: ADD R1 ; ADD R2,R3,R1
    drain();
    drive_d(1'b1, 4'd9, 4'd10, 4'd1, 1'b1, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd3, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (fwd !== 4'b0010) begin failures++; $display("FAIL fwdB_dist1 got=%b exp=%b", fwd, 4'b0010); end
    // R1 written by both M and W: the newer (M) wins
    drain();
    drive_d(1'b1, 4'd9, 4'd10, 4'd1, 1'b1, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd9, 4'd10, 4'd1, 1'b1, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd1, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (fwd !== 4'b1010) begin failures++; $display("FAIL fwd_m_priority got=%b exp=%b", fwd, 4'b1010); end
    // producer with RegWrite=0 never forwards
    drain();
    drive_d(1'b1, 4'd9, 4'd10, 4'd1, 1'b0, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd1, 4'd1, 4'd2, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (fwd !== 4'b0000) begin failures++; $display("FAIL fwd_nowrite got=%b exp=%b", fwd, 4'b0000); end
  endtask

  task automatic test_load_use();
    // LDR R4 ; SUB R5,R4,R6
    drain();
    drive_d(1'b1, 4'd9, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0); tick();
    drive_d(1'b1, 4'd4, 4'd6, 4'd5, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_LDUSE) begin failures++; $display("FAIL lduse_stall got=%b exp=%b", ctl, C_LDUSE); end
    tick();
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL lduse_release got=%b exp=%b", ctl, C_NONE); end
    tick();
    checks++;
    if (fwd !== 4'b0100) begin failures++; $display("FAIL lduse_fwd got=%b exp=%b", fwd, 4'b0100); end
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL lduse_after got=%b exp=%b", ctl, C_NONE); end
    // match on Rm
    drain();
    drive_d(1'b1, 4'd9, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0); tick();
    drive_d(1'b1, 4'd6, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_LDUSE) begin failures++; $display("FAIL lduse_rm got=%b exp=%b", ctl, C_LDUSE); end
    // independent consumer and a bubble in D: no stall
    drain();
    drive_d(1'b1, 4'd9, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0); tick();
    drive_d(1'b1, 4'd5, 4'd6, 4'd7, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL lduse_nomatch got=%b exp=%b", ctl, C_NONE); end
    drive_d(1'b0, 4'd4, 4'd4, 4'd7, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL lduse_bubble got=%b exp=%b", ctl, C_NONE); end
  endtask

  task automatic test_mul();
    // MUL R7 ; ADD R8,R7,R7
    drain();
    drive_d(1'b1, 4'd9, 4'd10, 4'd7, 1'b1, 1'b0, 1'b1); tick();
    drive_d(1'b1, 4'd7, 4'd7, 4'd8, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (ctl !== C_MULBSY) begin failures++; $display("FAIL mul_busy1 got=%b exp=%b", ctl, C_MULBSY); end
    tick();
    checks++;
    if (ctl !== C_MULBSY) begin failures++; $display("FAIL mul_busy2 got=%b exp=%b", ctl, C_MULBSY); end
    tick();
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL mul_done got=%b exp=%b", ctl, C_NONE); end
    tick();
    checks++;
    if (fwd !== 4'b1010) begin failures++; $display("FAIL mul_fwd got=%b exp=%b", fwd, 4'b1010); end
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL mul_after got=%b exp=%b", ctl, C_NONE); end
  endtask

  task automatic test_branch();
    // taken branch coinciding with a load-use match
    drain();
    drive_d(1'b1, 4'd9, 4'd0, 4'd4, 1'b1, 1'b1, 1'b0); tick();
    drive_d(1'b1, 4'd4, 4'd6, 4'd5, 1'b1, 1'b0, 1'b0);
    BranchTakenE = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin failures++; $display("FAIL br_lduse got=%b exp=%b", ctl, C_BRANCH); end
    tick();
    BranchTakenE = 1'b0;
    drive_nop();
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL br_after got=%b exp=%b", ctl, C_NONE); end
    // taken branch alone
    drive_d(1'b1, 4'd5, 4'd6, 4'd7, 1'b1, 1'b0, 1'b0);
    BranchTakenE = 1'b1;
    #1;
    checks++;
    if (ctl !== C_BRANCH) begin failures++; $display("FAIL br_alone got=%b exp=%b", ctl, C_BRANCH); end
    BranchTakenE = 1'b0;
  endtask

  task automatic test_pc();
    // older instruction writes R15; consumer reads R15 on both ports
    drain();
    drive_d(1'b1, 4'd9, 4'd10, 4'd15, 1'b1, 1'b0, 1'b0); tick();
    drive_d(1'b1, 4'd15, 4'd15, 4'd3, 1'b1, 1'b0, 1'b0); tick();
    checks++;
    if (fwd !== 4'b0000) begin failures++; $display("FAIL pc_nofwd got=%b exp=%b", fwd, 4'b0000); end
  endtask

  task automatic test_reset_mid_mul();
    drain();
    drive_d(1'b1, 4'd9, 4'd10, 4'd7, 1'b1, 1'b0, 1'b1); tick();
    drive_nop();
    tick();
    checks++;
    if (ctl !== C_MULBSY) begin failures++; $display("FAIL rmul_busy2 got=%b exp=%b", ctl, C_MULBSY); end
    reset_n = 1'b0;
    BranchTakenE = 1'b1;
    drive_d(1'b1, 4'd7, 4'd7, 4'd8, 1'b1, 1'b0, 1'b0);
    #2;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL rmul_reset_ctl got=%b exp=%b", ctl, C_NONE); end
    reset_n = 1'b1;
    BranchTakenE = 1'b0;
    drive_nop();
    #1;
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL rmul_release got=%b exp=%b", ctl, C_NONE); end
    tick();
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL rmul_residual1 got=%b exp=%b", ctl, C_NONE); end
    tick();
    checks++;
    if (ctl !== C_NONE) begin failures++; $display("FAIL rmul_residual2 got=%b exp=%b", ctl, C_NONE); end
  endtask

  initial begin
    reset_n      = 1'b0;
    BranchTakenE = 1'b0;
    drive_nop();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_mul();
    test_branch();
    test_pc();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage ARM core; sequences the EX-stage operand forwarding muxes, pipeline stalls and flushes.
- Tracks destination/source register info of the instructions in E, M and W in an internal shadow pipeline fed from Decode.
- Generates ForwardA/ForwardB, load-use stalls, branch flushes, and multi-cycle stalls for multiply ops that hold EX for MUL_LAT cycles.

Parameters:
- REG_AW, 4, register address width (16 architectural registers).
- MUL_LAT, 3, cycles a multiply occupies EX (>=1; 1 = no stall).

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- ValidD  in  1  Decode holds a real instruction (0 = bubble).
- RA1D  in  REG_AW  Decode source register 1 (Rn).
- RA2D  in  REG_AW  Decode source register 2 (Rm).
- WA3D  in  REG_AW  Decode destination register.
- RegWriteD  in  1  Decode instruction writes the register file.
- MemtoRegD  in  1  Decode instruction is a load.
- MulD  in  1  Decode instruction is a multi-cycle multiply.
- BranchTakenE  in  1  branch resolved taken in EX this cycle.
- ForwardA  out  2  SrcA select: 00 regfile, 01 ResultW, 10 ALUResultM.
- ForwardB  out  2  SrcB select, same encoding.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- StallE  out  1  hold D/E register.
- FlushD  out  1  clear F/D register.
- FlushE  out  1  clear D/E register (bubble).
- FlushM  out  1  clear E/M register (bubble).

Behaviour:
- Reset (async, reset_n=0): all shadow fields (E: RA1E, RA2E, WA3E, RegWriteE, MemtoRegE, MulE; M: WA3M, RegWriteM; W: WA3W, RegWriteW) cleared; mul counter = 0. All outputs are 0 while reset is held. A reset mid-multiply abandons the multiply.
- Forwarding is combinational from the shadow:
  - ForwardA = 10 if RegWriteM && WA3M==RA1E; else 01 if RegWriteW && WA3W==RA1E; else 00. M has priority over W.
  - ForwardB uses the same rule with RA2E.
  - RA==15 (PC) never forwards; the result is 00.
  - ForwardB is produced regardless of ALUSrc; immediate selection is downstream.
- Load-use stall: ldstall = ValidD && RegWriteE && MemtoRegE && (WA3E==RA1D || WA3E==RA2D). It asserts StallF, StallD and FlushE; the E shadow receives a bubble (all write/flag fields 0).
- Branch: BranchTakenE asserts FlushD and FlushE. Branch has priority over ldstall: when both are true, StallF and StallD are 0. The E shadow is bubbled and M/W advance normally.
- Multiply sequencer (cnt, width clog2(MUL_LAT+1)):
  - On the edge a MulD instruction enters E with MUL_LAT>1, cnt is loaded with MUL_LAT-1.
  - While cnt!=0: StallF, StallD and StallE are 1; FlushM is 1; ldstall and FlushE are suppressed; the E shadow holds; M is loaded with a bubble; W advances; cnt decrements.
  - The cycle cnt reaches 0, the multiply advances normally.
  - Net effect: the multiply occupies EX for exactly MUL_LAT cycles and inserts MUL_LAT-1 M bubbles.
  - Forward selects are recomputed each busy cycle (W drains; the register file is write-through, so 00 is correct after W retires).
- Shadow advance with no stall: E<=D fields (bubble if !ValidD or FlushE), M<=E, W<=M.
- Outputs are mutually consistent:
  - StallE implies StallF and StallD.
  - FlushE is never asserted together with StallE.

Decomposition:
- Shared package arm_pipe_pkg: FWD_REGFILE=2'b00, FWD_RESULTW=2'b01, FWD_ALURESM=2'b10; REG_PC=4'd15; stage shadow struct type (wa, regwrite, memtoreg, mul, ra1, ra2).
- One sub-module: hazard_fwd_sel, the combinational forward-select compare, instantiated twice (A and B).

Test Plan:
- ADD R1 then ADD R2,R1,R3 back-to-back -> ForwardA=10 in the consumer's EX cycle; with one instruction between them -> ForwardA=01; two between -> 00.
- LDR R4 followed by SUB R5,R4,R6 -> one cycle with StallF=StallD=FlushE=1; next cycle ForwardA=01; no stall otherwise.
- MUL R7 with MUL_LAT=3, then ADD R8,R7,R7 -> StallE=FlushM=1 for 2 cycles; the ADD sees ForwardA=ForwardB=10 when the MUL is in M.
- BranchTakenE=1 in the same cycle as a load-use match -> FlushD=FlushE=1, StallF=StallD=0; no stall the following cycle.
- Instruction using R15 as Rn, with an older instruction writing R15 in M -> ForwardA=00.
- reset_n pulled low during cycle 2 of a MUL_LAT=3 stall -> all outputs 0 immediately; after release, cnt=0 and the pipeline advances with no residual stall.
